// File: rtl/m_ifetch_q_pkg.sv
// Shared definitions for the instruction prefetch queue: NOP encoding,
// fetch FSM state codes, default queue depth and the queue entry layout.
package m_ifetch_q_pkg;

   localparam logic [31:0] NOP           = 32'h0000_0020;
   localparam int          DEFAULT_DEPTH = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] pc;
      logic [31:0] pc4;
   } fq_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/m_ifetch_q_fifo.sv
// Circular prefetch buffer: head/tail pointers plus occupancy count,
// synchronous flush that overrides push and pop in the same cycle.
module m_ififo
   import m_ifetch_q_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                     w_clk,
   input  logic                     w_rst_n,
   input  logic                     w_flush,
   input  logic                     w_push,
   input  logic [31:0]              w_din_ir,
   input  logic [31:0]              w_din_pc,
   input  logic [31:0]              w_din_pc4,
   input  logic                     w_pop,
   output logic                     r_valid,
   output logic [31:0]              r_ir,
   output logic [31:0]              r_pc,
   output logic [31:0]              r_pc4,
   output logic [$clog2(DEPTH):0]   r_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   fq_entry_t       mem_q [DEPTH];
   fq_entry_t       din;
   fq_entry_t       head_e;
   logic [AW-1:0]   head_q, head_d;
   logic [AW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            do_push, do_pop;

   assign din = '{ir: w_din_ir, pc: w_din_pc, pc4: w_din_pc4};

   always_comb begin
      do_pop  = w_pop && (cnt_q != '0);
      // a full buffer still accepts a push when the head leaves this cycle
      do_push = w_push && ((cnt_q != FULL_C) || do_pop);
      head_d  = head_q;
      tail_d  = tail_q;
      cnt_d   = cnt_q;
      if (w_flush) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end else begin
         if (do_pop)  head_d = head_q + 1'b1;
         if (do_push) tail_d = tail_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge w_clk) begin
      if (do_push && !w_flush) mem_q[tail_q] <= din;
   end

   assign head_e  = mem_q[head_q];
   assign r_valid = (cnt_q != '0);
   assign r_ir    = r_valid ? head_e.ir  : NOP;
   assign r_pc    = r_valid ? head_e.pc  : 32'h0;
   assign r_pc4   = r_valid ? head_e.pc4 : 32'h0;
   assign r_count = cnt_q;

endmodule

// File: rtl/m_ifetch_q.sv
// Instruction fetch front end: issues word fetches to a synchronous imem,
// tags responses with their PC and buffers them for ID in m_ififo.
module m_ifetch_q
   import m_ifetch_q_pkg::*;
#(
   parameter int          DEPTH    = DEFAULT_DEPTH,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        w_clk,
   input  logic        w_rst_n,
   input  logic        w_redirect,
   input  logic [31:0] w_tpc,
   input  logic        w_halt,
   input  logic        w_stall,
   output logic [11:0] r_iaddr,
   input  logic [31:0] w_ird,
   output logic        w_valid,
   output logic [31:0] w_ir,
   output logic [31:0] w_pc,
   output logic [31:0] w_pc4
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int OW = CW + 1;
   localparam logic [OW-1:0] DEPTH_OCC = OW'(DEPTH);

   logic [1:0]    state_q, state_d;
   logic [31:0]   fpc_q, fpc_d;
   logic [31:0]   tag_q, tag_d;
   logic          pend_q, pend_d;
   logic          hreq_q, hreq_d;
   logic [CW-1:0] count;
   logic [OW-1:0] occ;
   logic          redir, halt_now, issue, pop;

   // entries held plus the response still in flight
   assign occ = {1'b0, count} + OW'(pend_q);

   always_comb begin
      state_d  = state_q;
      hreq_d   = hreq_q;
      redir    = (state_q == ST_RUN) && w_redirect;
      halt_now = w_halt || hreq_q;
      case (state_q)
         // a halt seen during the single IDLE cycle is held so RUN honours it
         ST_IDLE: begin
            state_d = ST_RUN;
            hreq_d  = w_halt;
         end
         ST_RUN:  if (halt_now) state_d = ST_HALT;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase

      issue  = (state_q == ST_RUN) && !halt_now && !redir && (occ < DEPTH_OCC);
      fpc_d  = fpc_q;
      tag_d  = tag_q;
      if (redir) begin
         fpc_d = align_pc(w_tpc);
      end else if (issue) begin
         fpc_d = fpc_q + 32'd4;
         tag_d = fpc_q;
      end
      // redirect leaves pend_d low, which kills the response on the wire
      pend_d = issue;
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q <= ST_IDLE;
         fpc_q   <= RESET_PC;
         tag_q   <= 32'h0;
         pend_q  <= 1'b0;
         hreq_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
         tag_q   <= tag_d;
         pend_q  <= pend_d;
         hreq_q  <= hreq_d;
      end
   end

   assign r_iaddr = fpc_q[13:2];
   assign pop     = w_valid && !w_stall;

   m_ififo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .w_clk     (w_clk),
      .w_rst_n   (w_rst_n),
      .w_flush   (redir),
      .w_push    (pend_q),
      .w_din_ir  (w_ird),
      .w_din_pc  (tag_q),
      .w_din_pc4 (tag_q + 32'd4),
      .w_pop     (pop),
      .r_valid   (w_valid),
      .r_ir      (w_ir),
      .r_pc      (w_pc),
      .r_pc4     (w_pc4),
      .r_count   (count)
   );

endmodule
